// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that shares the single sync_fifo
// write port among NUM_REQ producers. A producer that wins holds the port for
// up to MAX_BURST words. Priority then rotates to the next producer. Writes
// are never issued while the FIFO reports full.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int IDX_W      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IDX_W-1:0]              owner,
  output logic                          busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic [7:0]       r_burst_cnt;

  logic [IDX_W-1:0]      w_winner;
  logic                  w_wr;
  logic                  w_burst_done;
  logic [DATA_WIDTH-1:0] w_slices [NUM_REQ];

  // Unpack the flat producer data bus into one word per producer
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_slices[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority search: the first requester at or after last_owner+1 wins.
  // The loop runs from the far end so that the closest requester is assigned last.
  always_comb begin
    int idx;
    w_winner = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_last_owner) + 1 + k) % NUM_REQ;
      if (req[idx]) begin
        w_winner = IDX_W'(idx);
      end
    end
  end

  // A word moves only while a tenure is open, the owner offers a word, and the FIFO has room
  assign w_wr         = (r_state == ST_OWN) && req[r_owner] && !fifo_full;
  assign w_burst_done = (r_burst_cnt == 8'(MAX_BURST - 1));

  assign fifo_write_en = w_wr;
  assign gnt           = w_wr ? (NUM_REQ'(1) << r_owner) : '0;
  assign fifo_data_in  = w_wr ? w_slices[r_owner] : '0;
  assign owner         = r_owner;
  assign busy          = (r_state == ST_OWN);

  // Tenure FSM: arbitrate in IDLE, then stream the owner's words until the burst ends or the owner drops req
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_owner     <= w_winner;
            r_burst_cnt <= '0;
            r_state     <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!req[r_owner]) begin
            // Owner has nothing more to offer: release even if the FIFO is full
            r_last_owner <= r_owner;
            r_state      <= ST_IDLE;
          end else if (w_wr) begin
            if (w_burst_done) begin
              r_last_owner <= r_owner;
              r_state      <= ST_IDLE;
            end else begin
              r_burst_cnt <= r_burst_cnt + 8'd1;
            end
          end
          // FIFO full with the owner still requesting: hold everything
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed producer scenarios. A scoreboard
// queue holds the expected (owner, word) order. A negedge monitor checks
// every write against that queue.
module tb_fifo_write_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             fifo_full;
  logic             fifo_write_en;
  logic [DW-1:0]    fifo_data_in;
  logic [IW-1:0]    owner;
  logic             busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .IDX_W(IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_write_en(fifo_write_en),
    .fifo_data_in (fifo_data_in),
    .owner        (owner),
    .busy         (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Producer models: each producer offers a list of words, one per grant
  logic [7:0]  words [NR][16];
  int          len [NR];
  int          ptr [NR];
  logic [15:0] exp_q [$];      // {owner, data}
  logic [7:0]  fifo_exp [$];   // expected FIFO read order in the last scenario
  logic [7:0]  fmem [$];       // FIFO model contents
  logic        fen;            // FIFO model drives fifo_full when set

  // Values sampled at the negedge of the most recent tick
  logic [NR-1:0] s_gnt;
  logic          s_we;
  logic [DW-1:0] s_data;
  logic [IW-1:0] s_owner;
  logic          s_busy;
  logic [15:0]   mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = (ptr[i] < len[i]);
      req_data[i*DW +: DW] = (ptr[i] < len[i]) ? words[i][ptr[i]] : 8'h00;
    end
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) words[i][k] = 8'(base + k);
    len[i] = n;
    ptr[i] = 0;
  endtask

  task automatic expect_words(input int i, input int from, input int cnt);
    for (int k = from; k < from + cnt; k++) exp_q.push_back({8'(i), words[i][k]});
  endtask

  // One clock cycle: sample at the negedge, then advance the producers and the FIFO model after the posedge
  task automatic tick();
    @(negedge clk);
    s_gnt   = gnt;
    s_we    = fifo_write_en;
    s_data  = fifo_data_in;
    s_owner = owner;
    s_busy  = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (s_gnt[i]) ptr[i]++;
    if (fen) begin
      if (s_we && !fifo_full) fmem.push_back(s_data);
      fifo_full = (fmem.size() == DEPTH);
    end
    drive();
  endtask

  // Reset is asserted between clock edges, and the outputs are checked before any edge arrives
  task automatic do_reset(input string tag);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk({tag, "_rst_gnt"}, gnt, 0);
    chk({tag, "_rst_we"}, fifo_write_en, 0);
    chk({tag, "_rst_data"}, fifo_data_in, 0);
    chk({tag, "_rst_owner"}, owner, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    for (int i = 0; i < NR; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    fen       = 1'b0;
    fifo_full = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: every write must match the next expected (owner, word)
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (fifo_write_en) begin
        chk("no_write_when_full", fifo_full, 0);
        chk("gnt_onehot", $onehot(gnt), 1);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got owner gnt 0x%0h data 0x%0h expected no write", gnt, fifo_data_in);
        end else begin
          mon_e = exp_q.pop_front();
          if (fifo_data_in !== mon_e[7:0] || gnt !== (NR'(1) << mon_e[15:8])) begin
            n_fail++;
            $display("FAIL sb_write: got gnt 0x%0h data 0x%0h expected gnt 0x%0h data 0x%0h",
                     gnt, fifo_data_in, NR'(1) << mon_e[15:8], mon_e[7:0]);
          end else begin
            $display("write: owner %0d data 0x%02h", mon_e[15:8], mon_e[7:0]);
          end
        end
      end else begin
        chk("gnt_idle", gnt, 0);
      end
    end
  end

  initial begin
    logic [31:0] we2 [10];
    logic [31:0] we4 [10];
    logic [31:0] we5 [8];
    we2 = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    we4 = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
    we5 = '{0, 1, 0, 0, 1, 1, 0, 0};

    for (int i = 0; i < NR; i++) begin
      len[i] = 0;
      ptr[i] = 0;
    end
    fen       = 1'b0;
    fifo_full = 1'b0;
    reset     = 1'b0;
    drive();
    #1;
    chk("init_gnt", gnt, 0);
    chk("init_we", fifo_write_en, 0);
    chk("init_data", fifo_data_in, 0);
    chk("init_owner", owner, 0);
    chk("init_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single producer: a burst of 4 words, one idle cycle, then 2 words, then release
    load(0, 8'h10, 6);
    expect_words(0, 0, 6);
    drive();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t2_we_c%0d", c), s_we, we2[c]);
      if (c == 6) chk("t2_busy_mid", s_busy, 1);
    end
    chk("t2_busy_end", busy, 0);
    chk("t2_owner_end", owner, 0);
    chk("t2_consumed", ptr[0], 6);
    do_reset("t2");

    // All four producers requesting: tenures 0,1,2,3,0 at 5 cycles each. Reset then arrives mid-activity.
    for (int i = 0; i < NR; i++) load(i, 8'h20 + i * 8'h10, 8);
    for (int i = 0; i < NR; i++) expect_words(i, 0, 4);
    expect_words(0, 4, 4);
    drive();
    for (int c = 0; c < 26; c++) begin
      tick();
      chk($sformatf("t3_gnt_c%0d", c), s_gnt,
          (c % 5 == 0) ? 32'd0 : (32'd1 << ((c / 5) % NR)));
    end
    chk("t3_owner_before_rst", owner, 1);
    chk("t3_gnt_before_rst", gnt, 4'b0010);
    // The write that would occur in this cycle is suppressed by the reset
    do_reset("t3");

    // Producer 2 owns the port: 2 writes, FIFO full for 3 cycles, 2 more writes, then release
    load(2, 8'h40, 4);
    expect_words(2, 0, 4);
    drive();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("t4_we_c%0d", c), s_we, we4[c]);
      if (c >= 3 && c <= 5) begin
        chk($sformatf("t4_owner_c%0d", c), s_owner, 2);
        chk($sformatf("t4_busy_c%0d", c), s_busy, 1);
      end
      if (c == 2) fifo_full = 1'b1;
      if (c == 5) fifo_full = 1'b0;
    end
    chk("t4_busy_end", s_busy, 0);
    chk("t4_owner_hold", s_owner, 2);
    do_reset("t4");

    // Producer 1 drops req after 1 write while producer 3 waits, so producer 3 wins next
    load(1, 8'h50, 1);
    load(3, 8'h70, 2);
    expect_words(1, 0, 1);
    expect_words(3, 0, 2);
    drive();
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("t5_we_c%0d", c), s_we, we5[c]);
      if (c == 1) chk("t5_owner_first", s_owner, 1);
      if (c == 2) chk("t5_release_busy", s_busy, 1);
      if (c == 3) chk("t5_arb_busy", s_busy, 0);
      if (c == 4) chk("t5_owner_next", s_owner, 3);
    end
    do_reset("t5");

    // Four producers stream into a depth-16 FIFO model until it fills
    fen = 1'b1;
    fmem.delete();
    fifo_exp.delete();
    for (int i = 0; i < NR; i++) load(i, 8'h80 + i * 8'h10, 8);
    for (int i = 0; i < NR; i++) begin
      expect_words(i, 0, 4);
      for (int k = 0; k < 4; k++) fifo_exp.push_back(words[i][k]);
    end
    drive();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c >= 20) chk($sformatf("t6_hold_we_c%0d", c), s_we, 0);
    end
    chk("t6_fifo_count", fmem.size(), DEPTH);
    chk("t6_full", fifo_full, 1);
    chk("t6_owner", owner, 0);
    chk("t6_busy", busy, 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("t6_read_%0d", k), (k < fmem.size()) ? fmem[k] : 8'hxx, fifo_exp[k]);
    end
    do_reset("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
